// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the 5-stage pipeline.
// Handles load-use stalls, ID-stage branch operand stalls, taken-branch IF/ID
// flush, and freezes the whole pipeline during multi-cycle data-memory access.
// Optional feature macro: HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_ctrl #(
    parameter int MEM_LAT = 2,   // data-memory latency in cycles, 1..16
    parameter int STAT_W  = 16   // statistics counter width
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        IF_ID_rs_i,
    input  logic [4:0]        IF_ID_rt_i,
    input  logic              IF_ID_use_rt_i,
    input  logic              IF_ID_branch_i,
    input  logic [4:0]        ID_EX_rd_i,
    input  logic              ID_EX_regwrite_i,
    input  logic              ID_EX_memread_i,
    input  logic [4:0]        EX_MEM_rd_i,
    input  logic              EX_MEM_memread_i,
    input  logic              branch_taken_i,
    input  logic              dmem_req_i,
    output logic              pc_write_o,
    output logic              IF_ID_write_o,
    output logic              IF_ID_flush_o,
    output logic              ID_EX_bubble_o,
    output logic              pipe_freeze_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cycles_o,
    output logic [STAT_W-1:0] flush_cnt_o
`endif
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    // A single-cycle memory never needs to freeze the pipeline.
    localparam logic       MULTI    = 1'(MEM_LAT > 1);
    // First WAIT-cycle count; the RUN cycle that starts the access already freezes.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);

    logic [0:0] state;
    logic [3:0] cnt;

    logic ex_match, mem_match;
    logic load_use, br_haz;
    logic freeze, stall, flush;

    // Producer/consumer matching; register 0 never creates a hazard.
    always_comb begin
        ex_match  = (ID_EX_rd_i != 5'd0) &&
                    ((ID_EX_rd_i == IF_ID_rs_i) ||
                     (IF_ID_use_rt_i && (ID_EX_rd_i == IF_ID_rt_i)));
        mem_match = (EX_MEM_rd_i != 5'd0) &&
                    ((EX_MEM_rd_i == IF_ID_rs_i) ||
                     (IF_ID_use_rt_i && (EX_MEM_rd_i == IF_ID_rt_i)));
        load_use  = ID_EX_memread_i && ex_match;
        br_haz    = IF_ID_branch_i &&
                    ((ID_EX_regwrite_i && ex_match) || (EX_MEM_memread_i && mem_match));
    end

    // Freeze is raised from the request cycle until the completion cycle (cnt==0).
    always_comb begin
        if (state == RUN) freeze = dmem_req_i && MULTI;
        else              freeze = (cnt != 4'd0);
        stall = (load_use || br_haz) && !freeze;
        flush = IF_ID_branch_i && branch_taken_i && !stall && !freeze;
    end

    // Output drive; reset forces PC/IF_ID writes open and everything else quiet.
    always_comb begin
        if (rst_i) begin
            pc_write_o     = 1'b1;
            IF_ID_write_o  = 1'b1;
            IF_ID_flush_o  = 1'b0;
            ID_EX_bubble_o = 1'b0;
            pipe_freeze_o  = 1'b0;
        end else begin
            pc_write_o     = !(stall || freeze);
            IF_ID_write_o  = !(stall || freeze);
            IF_ID_flush_o  = flush;
            ID_EX_bubble_o = stall;
            pipe_freeze_o  = freeze;
        end
    end

    // Memory-wait FSM: RUN launches a wait, WAIT counts down to the completion cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_req_i && MULTI) begin
                        state <= WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RUN;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [STAT_W-1:0] ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    // Saturating statistics: lost cycles (stall or freeze) and IF/ID flushes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_o <= '0;
            flush_cnt_o    <= '0;
        end else begin
            if ((stall || freeze) && (stall_cycles_o != '1))
                stall_cycles_o <= stall_cycles_o + ONE;
            if (flush && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + ONE;
        end
    end
`endif

endmodule
